// File: rtl/riscv_core_amo_seq.sv
// RV32A atomic sequencer for the memory stage.
// Accepts one LR/SC/AMO request at a time, performs the data-memory read,
// feeds the external AMO ALU from registers, writes the result back, keeps
// the single LR reservation and returns the rd value to the core.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a new request
// RD_REQ  | read request on the memory bus, waiting for grant
// RD_WAIT | read granted, waiting for read data
// WR_REQ  | write request on the memory bus (AMO result or SC data)
// RESP    | one-cycle response to the core
module riscv_core_amo_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [4:0]            i_funct5,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_resp_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [3:0]            o_amo_op,
  output logic [DATA_WIDTH-1:0] o_alu_mem_data,
  output logic [DATA_WIDTH-1:0] o_alu_core_data,
  input  logic [DATA_WIDTH-1:0] i_amo_alu_result,
  input  logic                  i_snoop_valid,
  input  logic [ADDR_WIDTH-1:0] i_snoop_addr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  localparam logic [1:0] KIND_AMO = 2'd0;
  localparam logic [1:0] KIND_LR  = 2'd1;
  localparam logic [1:0] KIND_SC  = 2'd2;

  logic [2:0]            state;
  logic [1:0]            kind_q;
  logic [3:0]            op_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resv_valid;
  logic [ADDR_WIDTH-3:0] resv_word;

  logic [3:0] dec_op;
  logic [1:0] dec_kind;
  logic       dec_legal;

  // Decode funct5 into ALU opcode, request kind and legality.
  always_comb begin
    dec_op    = 4'd0;
    dec_kind  = KIND_AMO;
    dec_legal = 1'b1;
    case (i_funct5)
      5'b00001: dec_op = 4'd0;
      5'b00000: dec_op = 4'd1;
      5'b01100: dec_op = 4'd2;
      5'b01000: dec_op = 4'd3;
      5'b00100: dec_op = 4'd4;
      5'b10100: dec_op = 4'd5;
      5'b10000: dec_op = 4'd6;
      5'b11100: dec_op = 4'd7;
      5'b11000: dec_op = 4'd8;
      5'b00010: dec_kind = KIND_LR;
      5'b00011: dec_kind = KIND_SC;
      default:  dec_legal = 1'b0;
    endcase
  end

  logic                  req_err;
  logic                  sc_accept;
  logic [ADDR_WIDTH-3:0] in_word;
  logic [ADDR_WIDTH-3:0] q_word;
  logic [ADDR_WIDTH-3:0] snoop_word;
  logic                  snoop_resv;
  logic                  snoop_in;
  logic                  snoop_q;
  logic                  sc_ok;
  logic                  unused_bits;

  assign req_err    = !dec_legal || (i_addr[1:0] != 2'b00);
  assign sc_accept  = (state == IDLE) && i_req_valid && !req_err && (dec_kind == KIND_SC);
  assign in_word    = i_addr[ADDR_WIDTH-1:2];
  assign q_word     = addr_q[ADDR_WIDTH-1:2];
  assign snoop_word = i_snoop_addr[ADDR_WIDTH-1:2];
  assign snoop_resv = i_snoop_valid && (snoop_word == resv_word);
  assign snoop_in   = i_snoop_valid && (snoop_word == in_word);
  assign snoop_q    = i_snoop_valid && (snoop_word == q_word);
  // A snoop to the SC address in the accept cycle makes the SC fail even if
  // the reservation register has not been cleared yet.
  assign sc_ok      = resv_valid && (resv_word == in_word) && !snoop_in;
  assign unused_bits = ^{i_snoop_addr[1:0], addr_q[1:0]};

  // Main sequencer: request capture, memory handshakes and response data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      kind_q      <= KIND_AMO;
      op_q        <= 4'd0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rs2_q       <= '0;
      rdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_q <= i_addr;
            rs2_q  <= i_rs2_data;
            op_q   <= dec_op;
            kind_q <= dec_kind;
            err_q  <= req_err;
            if (req_err) begin
              resp_data_q <= '0;
              state       <= RESP;
            end else if (dec_kind == KIND_SC) begin
              if (sc_ok) begin
                resp_data_q <= '0;
                state       <= WR_REQ;
              end else begin
                resp_data_q <= DATA_WIDTH'(1);
                state       <= RESP;
              end
            end else begin
              state <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (i_mem_gnt) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i_mem_rvalid) begin
            rdata_q     <= i_mem_rdata;
            resp_data_q <= i_mem_rdata;
            state       <= (kind_q == KIND_LR) ? RESP : WR_REQ;
          end
        end
        WR_REQ: begin
          if (i_mem_gnt) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // LR reservation: set by LR read data, cleared by SC, by a matching AMO
  // write, or by a store from another master to the same word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      resv_valid <= 1'b0;
      resv_word  <= '0;
    end else begin
      if (snoop_resv) resv_valid <= 1'b0;
      if (sc_accept) resv_valid <= 1'b0;
      if ((state == RD_WAIT) && i_mem_rvalid && (kind_q == KIND_LR)) begin
        resv_word  <= q_word;
        resv_valid <= !snoop_q;
      end
      if ((state == WR_REQ) && i_mem_gnt && (kind_q == KIND_AMO) && (q_word == resv_word))
        resv_valid <= 1'b0;
    end
  end

  assign o_req_ready     = (state == IDLE);
  assign o_mem_req       = (state == RD_REQ) || (state == WR_REQ);
  assign o_mem_we        = (state == WR_REQ);
  assign o_mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_wdata     = (kind_q == KIND_SC) ? rs2_q : i_amo_alu_result;
  assign o_resp_valid    = (state == RESP);
  assign o_resp_err      = (state == RESP) && err_q;
  assign o_resp_data     = resp_data_q;
  assign o_amo_op        = op_q;
  assign o_alu_mem_data  = rdata_q;
  assign o_alu_core_data = rs2_q;

endmodule

// File: doc/riscv_core_amo_seq.md
# riscv_core_amo_seq

Sequencer for RV32A atomics in the memory stage. It accepts one LR/SC/AMO request from the pipeline and performs the data-memory read. It drives the AMO ALU's operand and opcode inputs and writes the ALU result back to memory. It also keeps the single LR reservation and returns the rd value to the core.

## Interface
- DATA_WIDTH, 32, data and ALU operand width
- ADDR_WIDTH, 32, byte address width
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  1  atomic request valid
- o_req_ready  out  1  sequencer idle and able to accept
- i_funct5  in  5  instruction bits [31:27]
- i_addr  in  ADDR_WIDTH  effective address (rs1)
- i_rs2_data  in  DATA_WIDTH  rs2 operand
- o_resp_valid  out  1  one-cycle response pulse
- o_resp_data  out  DATA_WIDTH  rd value
- o_resp_err  out  1  misaligned or illegal funct5
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  ADDR_WIDTH  word-aligned address
- o_mem_wdata  out  DATA_WIDTH  write data
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  DATA_WIDTH  read data
- o_amo_op  out  4  ALU opcode
- o_alu_mem_data  out  DATA_WIDTH  ALU memory operand
- o_alu_core_data  out  DATA_WIDTH  ALU core operand
- i_amo_alu_result  in  DATA_WIDTH  ALU result (combinational)
- i_snoop_valid  in  1  store by another master
- i_snoop_addr  in  ADDR_WIDTH  address of that store

## Operation
- funct5 decoding into o_amo_op:
  - AMOSWAP 00001→0000, AMOADD 00000→0001, AMOAND 01100→0010
  - AMOOR 01000→0011, AMOXOR 00100→0100
  - AMOMAX 10100→0101, AMOMIN 10000→0110, AMOMAXU 11100→0111, AMOMINU 11000→1000
  - LR 00010, SC 00011. Any other value is illegal.
- Accept on i_req_valid & o_req_ready. On accept, latch addr, rs2, decoded op and kind.
- o_amo_op, o_alu_core_data (rs2_q) and o_alu_mem_data (rdata_q) are driven from registers only.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE on accept:
  - err (addr[1:0]≠0 or illegal funct5) → RESP with data 0, err 1, no memory access.
  - AMO or LR → RD_REQ.
  - SC → WR_REQ if the reservation is valid and addr[ADDR_WIDTH-1:2] matches; otherwise RESP with data 1. The reservation is cleared in either case.
- RD_REQ: o_mem_req=1, we=0, held until i_mem_gnt, then → RD_WAIT.
- RD_WAIT: on i_mem_rvalid, latch rdata_q.
  - LR → RESP and set the reservation to this address.
  - AMO → WR_REQ.
- WR_REQ: o_mem_req=1, we=1, held until gnt, then → RESP.
  - wdata = i_amo_alu_result for AMO, rs2_q for SC.
  - An AMO write whose address matches the reservation clears it.
- RESP: o_resp_valid=1 for one cycle, then → IDLE. o_resp_data is:
  - rdata_q for AMO and LR
  - 0 for SC success, 1 for SC failure
  - 0 on error
- o_mem_addr = {addr_q[ADDR_WIDTH-1:2],2'b00}; it stays stable while o_mem_req is high.
- Snoop: i_snoop_valid with a matching word address clears the reservation in any state.
  - If a snoop coincides with the LR rvalid cycle on the same address, the reservation is not set.
  - If a snoop coincides with an SC accept on the same address, the SC fails.
- i_mem_rvalid outside RD_WAIT is ignored.

## Timing
- Reset (i_rst_n low at an edge) forces:
  - state IDLE, reservation invalid
  - o_mem_req=0, o_mem_we=0, o_resp_valid=0, o_resp_err=0
  - o_resp_data, rdata_q, rs2_q, addr_q and o_amo_op all 0
  - Requests are ignored while reset is low.
- Reset mid-operation aborts the operation with no response. Later memory responses are ignored.
- o_req_ready = (state==IDLE). No back-to-back accept while the response is pending.
- Minimum latency (gnt same cycle, rvalid one cycle after gnt), accept = cycle 0:
  - AMO: resp at cycle 4.
  - LR: resp at cycle 3.
  - SC success: resp at cycle 2.
  - SC fail or error: resp at cycle 1.
- Each extra cycle of gnt or rvalid delay adds one cycle of latency. There is no timeout.

## Test plan
- AMOADD, addr 0x100, mem=5, rs2=7: one read of 0x100, then one write of 12; resp_data=5 at cycle 4; o_amo_op=0001.
- AMOMINU, mem 0xFFFFFFFF, rs2 1: write 1, resp 0xFFFFFFFF. AMOMIN with the same values: write 0xFFFFFFFF.
- LR 0x200 (mem=9) → resp 9; then SC 0x200, rs2=3 → write 3, resp 0. A second SC → resp 1 with no memory request.
- LR 0x200, then snoop 0x202, then SC 0x200 → resp 1, no write. Repeat with the snoop in the SC accept cycle → fail.
- Misaligned AMOSWAP at 0x101 → resp err=1, data 0, at cycle 1, no o_mem_req. funct5=11111 → same.
- gnt delayed 3 cycles with req/addr held stable; reset asserted in RD_WAIT → IDLE next cycle, no response, later rvalid ignored.
